key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan_pkg.sv | 44 ++++
 rtl/key_sync.sv | 28 ++
 rtl/key_scan.sv | 151 +++++++++++++++
 tb/tb_key_scan.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared definitions for the push-button scanner: FSM encoding, default timing
// constants and small key-code helpers.
package key_scan_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    localparam int unsigned DB_CYC_DEF   = 32'd1_000_000;
    localparam int unsigned LONG_CYC_DEF = 32'd50_000_000;
    localparam int unsigned REP_CYC_DEF  = 32'd10_000_000;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] code;
        case (idx)
            2'd0:    code = 4'b0001;
            2'd1:    code = 4'b0010;
            2'd2:    code = 4'b0100;
            2'd3:    code = 4'b1000;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // Keys are active-low; the lowest pressed index wins a tie.
    function automatic logic [1:0] lowest_low(input logic [3:0] k);
        logic [1:0] idx;
        if (!k[0]) begin
            idx = 2'd0;
        end else if (!k[1]) begin
            idx = 2'd1;
        end else if (!k[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-stage synchronizer for asynchronous inputs; resets to all-ones so idle
// (released) buttons are seen during and straight after reset.
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Synchronizer chain with active-high synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            meta_r <= {WIDTH{1'b1}};
            sync_r <= {WIDTH{1'b1}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/key_scan.sv
// Four-button scanner: debounces one key at a time and emits first-press and
// auto-repeat events as single-cycle strobes with a one-hot key code.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int unsigned DB_CYC   = DB_CYC_DEF,
    parameter int unsigned LONG_CYC = LONG_CYC_DEF,
    parameter int unsigned REP_CYC  = REP_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    output logic [3:0] dout,
    output logic       dout_vld,
    output logic       dout_rpt
);

    localparam int unsigned MAX_A   = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > REP_CYC) ? MAX_A : REP_CYC;
    localparam int          CNT_W   = $clog2(MAX_CYC + 32'd1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 32'd1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

    logic [3:0]       key_s;
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       sel_r, sel_s;
    logic             evt_s, evt_rpt_s;
    logic             evt_r, evt_rpt_r;
    logic [3:0]       dout_r;
    logic             dout_vld_r, dout_rpt_r;
    logic             sel_up_s;

    key_sync #(.WIDTH(4)) u_key_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (key),
        .dout  (key_s)
    );

    assign sel_up_s = key_s[sel_r];

    // Next-state, counter and event decode for the shared scan FSM
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sel_s     = sel_r;
        evt_s     = 1'b0;
        evt_rpt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_s != 4'b1111) begin
                    sel_s   = lowest_low(key_s);
                    cnt_s   = '0;
                    state_s = PRESS_DB;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_DB: begin
                if (sel_up_s) begin
                    cnt_s   = '0;
                    state_s = IDLE;
                end else if (cnt_r == DB_LAST) begin
                    evt_s   = 1'b1;
                    cnt_s   = '0;
                    state_s = HELD;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (sel_up_s) begin
                    cnt_s   = '0;
                    state_s = RELEASE_DB;
                end else if (cnt_r == LONG_LAST) begin
                    evt_s     = 1'b1;
                    evt_rpt_s = 1'b1;
                    cnt_s     = '0;
                    state_s   = REPEAT;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            REPEAT: begin
                if (sel_up_s) begin
                    cnt_s   = '0;
                    state_s = RELEASE_DB;
                end else if (cnt_r == REP_LAST) begin
                    evt_s     = 1'b1;
                    evt_rpt_s = 1'b1;
                    cnt_s     = '0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RELEASE_DB: begin
                // Every key, not just sel, must stay up for the full window.
                if (key_s != 4'b1111) begin
                    cnt_s = '0;
                end else if (cnt_r == DB_LAST) begin
                    cnt_s   = '0;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase
    end

    // State, counter, event pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            sel_r      <= 2'd0;
            evt_r      <= 1'b0;
            evt_rpt_r  <= 1'b0;
            dout_r     <= 4'b0000;
            dout_vld_r <= 1'b0;
            dout_rpt_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sel_r      <= sel_s;
            evt_r      <= evt_s;
            evt_rpt_r  <= evt_rpt_s;
            dout_vld_r <= evt_r;
            // sel only changes from IDLE, never the cycle after an event
            if (evt_r) begin
                dout_r     <= onehot4(sel_r);
                dout_rpt_r <= evt_rpt_r;
            end else begin
                dout_r     <= dout_r;
                dout_rpt_r <= dout_rpt_r;
            end
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign dout_rpt = dout_rpt_r;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a hold-length based reference model checked
// every cycle, plus hand-computed latency, code and spacing expectations.
module tb_key_scan;

    localparam int DB   = 4;
    localparam int LONG = 16;
    localparam int REP  = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] dout;
    logic       dout_vld;
    logic       dout_rpt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit check_en = 1'b0;

    int         pulse_cnt = 0;
    int         pulse_cyc[$];
    logic [3:0] pulse_dout[$];
    logic       pulse_rpt[$];

    // reference model state
    logic [3:0] h1 = 4'hF;
    logic [3:0] h2 = 4'hF;
    bit         busy = 1'b0;
    bit         releasing = 1'b0;
    int         hold = 0;
    int         run = 0;
    int         m_sel = 0;
    bit         pend_vld = 1'b0;
    bit         pend_rpt = 1'b0;
    int         pend_sel = 0;
    logic       exp_vld = 1'b0;
    logic [3:0] exp_dout = 4'b0000;
    logic       exp_rpt = 1'b0;

    key_scan #(.DB_CYC(DB), .LONG_CYC(LONG), .REP_CYC(REP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rpt (dout_rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One model step per rising edge: events are defined by how long the
    // selected key has been seen low since the press began.
    task automatic model_step();
        logic [3:0] ks;
        if (rst_n) begin
            h1 = 4'hF; h2 = 4'hF;
            busy = 1'b0; releasing = 1'b0; hold = 0; run = 0; m_sel = 0;
            pend_vld = 1'b0; pend_rpt = 1'b0; pend_sel = 0;
            exp_vld = 1'b0; exp_dout = 4'b0000; exp_rpt = 1'b0;
        end else begin
            ks = h2;
            exp_vld = pend_vld;
            if (pend_vld) begin
                exp_dout = 4'b0001 << pend_sel;
                exp_rpt  = pend_rpt;
            end
            pend_vld = 1'b0;
            if (!busy) begin
                if (ks != 4'hF) begin
                    for (int i = 3; i >= 0; i--) if (!ks[i]) m_sel = i;
                    busy = 1'b1; releasing = 1'b0; hold = 0;
                end
            end else if (!releasing) begin
                if (ks[m_sel]) begin
                    if (hold < DB) busy = 1'b0;
                    else begin releasing = 1'b1; run = 0; end
                end else begin
                    hold++;
                    if (hold == DB) begin
                        pend_vld = 1'b1; pend_rpt = 1'b0; pend_sel = m_sel;
                    end else if (hold >= DB + LONG && (hold - DB - LONG) % REP == 0) begin
                        pend_vld = 1'b1; pend_rpt = 1'b1; pend_sel = m_sel;
                    end
                end
            end else begin
                if (ks == 4'hF) begin
                    run++;
                    if (run == DB) busy = 1'b0;
                end else begin
                    run = 0;
                end
            end
            h2 = h1;
            h1 = key;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, plus pulse logging
    initial forever begin
        @(negedge clk);
        cyc++;
        if (check_en) begin
            check("vld", 32'(dout_vld), 32'(exp_vld));
            check("dout", 32'(dout), 32'(exp_dout));
            check("rpt", 32'(dout_rpt), 32'(exp_rpt));
        end
        if (dout_vld === 1'b1) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            pulse_dout.push_back(dout);
            pulse_rpt.push_back(dout_rpt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a key pattern and count edges until dout_vld; -1 on timeout.
    task automatic press_measure(input logic [3:0] v, output int lat);
        key = v;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (dout_vld === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int p0;
        rst_n = 1'b1;
        key   = 4'hF;
        tick(3);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_vld", 32'(dout_vld), 32'h0);
        check("reset_rpt", 32'(dout_rpt), 32'h0);
        check_en = 1'b1;
        rst_n = 1'b0;
        tick(3);

        // single press, release, no further events
        p0 = pulse_cnt;
        press_measure(4'b1110, lat);
        check("t1_latency", 32'(lat), 32'd7);
        check("t1_dout", 32'(dout), 32'h1);
        check("t1_rpt", 32'(dout_rpt), 32'h0);
        tick(2);
        key = 4'hF;
        tick(20);
        check("t1_pulses", 32'(pulse_cnt - p0), 32'd1);

        // short glitch on key 2
        p0 = pulse_cnt;
        key = 4'b1011;
        tick(3);
        key = 4'hF;
        tick(15);
        check("t2_pulses", 32'(pulse_cnt - p0), 32'd0);

        // long hold with auto-repeat
        pulse_cyc.delete(); pulse_dout.delete(); pulse_rpt.delete();
        key = 4'b1101;
        tick(60);
        key = 4'hF;
        tick(12);
        check("t3_count", 32'(pulse_cyc.size()), 32'd6);
        if (pulse_cyc.size() >= 4) begin
            check("t3_first_rpt", 32'(pulse_rpt[0]), 32'h0);
            check("t3_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd16);
            check("t3_gap2", 32'(pulse_cyc[2] - pulse_cyc[0]), 32'd24);
            check("t3_gap3", 32'(pulse_cyc[3] - pulse_cyc[2]), 32'd8);
            check("t3_rpt1", 32'(pulse_rpt[1]), 32'h1);
            check("t3_dout", 32'(pulse_dout[3]), 32'h2);
        end else begin
            check("t3_enough_pulses", 32'(pulse_cyc.size()), 32'd4);
        end

        // simultaneous keys 0 and 3: lowest wins
        press_measure(4'b0110, lat);
        check("t4_latency", 32'(lat), 32'd7);
        check("t4_dout", 32'(dout), 32'h1);
        tick(2);
        key = 4'hF;
        tick(10);

        // key 3 ignored while any key is still held
        press_measure(4'b1110, lat);
        check("t5_latency", 32'(lat), 32'd7);
        p0 = pulse_cnt;
        key = 4'b0110;
        tick(5);
        key = 4'b0111;
        tick(30);
        check("t5_ignored", 32'(pulse_cnt - p0), 32'd0);
        key = 4'hF;
        tick(10);
        press_measure(4'b0111, lat);
        check("t5_k3_latency", 32'(lat), 32'd7);
        check("t5_k3_dout", 32'(dout), 32'h8);
        key = 4'hF;
        tick(10);

        // release bounce
        press_measure(4'b1110, lat);
        check("t6_latency", 32'(lat), 32'd7);
        p0 = pulse_cnt;
        tick(2);
        key = 4'hF;
        tick(2);
        key = 4'b1110;
        tick(1);
        key = 4'hF;
        tick(20);
        check("t6_pulses", 32'(pulse_cnt - p0), 32'd0);

        // reset during HELD clears outputs
        press_measure(4'b1011, lat);
        check("t7_dout_before", 32'(dout), 32'h4);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("t7_rst_dout", 32'(dout), 32'h0);
        check("t7_rst_vld", 32'(dout_vld), 32'h0);
        check("t7_rst_rpt", 32'(dout_rpt), 32'h0);
        key = 4'hF;
        rst_n = 1'b0;
        tick(10);

        // reset during HELD with key still held: fresh first press
        press_measure(4'b1110, lat);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        press_measure(4'b1110, lat);
        check("t8_latency", 32'(lat), 32'd7);
        check("t8_rpt", 32'(dout_rpt), 32'h0);
        check("t8_dout", 32'(dout), 32'h1);
        key = 4'hF;
        tick(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
